// File: rtl/i2s_rx_deserializer.sv
// I2S capture-path deserializer: synchronizes bclk/lrclk/sdata into clk and
// delivers left/right words as a parallel pair with a one-cycle strobe.
module i2s_rx_deserializer #(
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i2s_bclk,
    input  logic                    i2s_lrclk,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] sample_l,
    output logic [SAMPLE_WIDTH-1:0] sample_r,
    output logic                    new_sample,
    output logic                    frame_error,
    output logic                    locked
);

    localparam logic [5:0]              CNT_W   = 6'(SAMPLE_WIDTH);
    localparam logic [SAMPLE_WIDTH-1:0] MSB_BIT = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);

    typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

    state_t                  state;
    logic                    bclk_s1, bclk_s2, bclk_s3;
    logic                    lr_s1, lr_s2, lr_prev;
    logic                    sd_s1, sd_s2;
    logic [5:0]              bit_cnt;
    logic [SAMPLE_WIDTH-1:0] shreg;
    logic [SAMPLE_WIDTH-1:0] left_hold;
    logic                    left_ok;

    logic bclk_rise;
    logic slot_ok;

    assign bclk_rise = bclk_s2 & ~bclk_s3;
    assign slot_ok   = (bit_cnt >= CNT_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
            lr_s1   <= 1'b0;
            lr_s2   <= 1'b0;
            sd_s1   <= 1'b0;
            sd_s2   <= 1'b0;
        end else begin
            bclk_s1 <= i2s_bclk;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            lr_s1   <= i2s_lrclk;
            lr_s2   <= lr_s1;
            sd_s1   <= i2s_sdata;
            sd_s2   <= sd_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WAIT_SYNC;
            lr_prev     <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            left_hold   <= '0;
            left_ok     <= 1'b0;
            sample_l    <= '0;
            sample_r    <= '0;
            new_sample  <= 1'b0;
            frame_error <= 1'b0;
            locked      <= 1'b0;
        end else begin
            new_sample  <= 1'b0;
            frame_error <= 1'b0;
            if (bclk_rise) begin
                lr_prev <= lr_s2;
                if (lr_s2 != lr_prev) begin
                    // Edge 0 of a slot carries the previous word's trailing bit.
                    bit_cnt <= '0;
                    shreg   <= '0;
                    case (state)
                        WAIT_SYNC: if (!lr_s2) state <= LEFT;
                        LEFT: if (lr_s2) begin
                            left_hold   <= shreg;
                            left_ok     <= slot_ok;
                            frame_error <= ~slot_ok;
                            state       <= RIGHT;
                        end
                        RIGHT: if (!lr_s2) begin
                            frame_error <= ~slot_ok;
                            if (left_ok && slot_ok) begin
                                sample_l   <= left_hold;
                                sample_r   <= shreg;
                                new_sample <= 1'b1;
                                locked     <= 1'b1;
                            end
                            state <= LEFT;
                        end
                        default: state <= WAIT_SYNC;
                    endcase
                end else begin
                    if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
                    // Bits land at absolute positions so a short slot keeps zero LSBs.
                    if (bit_cnt < CNT_W && sd_s2) shreg <= shreg | (MSB_BIT >> bit_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: slot-level stimulus with a per-slot
// reference model predicting strobes, errors, words and strobe timing.
module tb_i2s_rx_deserializer;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i2s_bclk = 1'b0;
    logic         i2s_lrclk = 1'b0;
    logic         i2s_sdata = 1'b0;
    logic [W-1:0] sample_l, sample_r;
    logic         new_sample, frame_error, locked;

    i2s_rx_deserializer #(.SAMPLE_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
        .i2s_sdata(i2s_sdata), .sample_l(sample_l), .sample_r(sample_r),
        .new_sample(new_sample), .frame_error(frame_error), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         lr;
        int         len;
        logic [W-1:0] word;
        bit         pad;
    } slot_t;

    typedef struct {
        int         kind;   // 1 = new_sample, 2 = frame_error, 3 = both at once
        logic [W-1:0] l;
        logic [W-1:0] r;
        int         cyc;
        logic       lk;
    } ev_t;

    slot_t slots[$];
    int    slot_rise[$];
    ev_t   obs[$];
    ev_t   expq[$];
    int    cyc = 0;
    int    half = 6;
    int    checks = 0;
    int    errors = 0;
    int    bad_change = 0;
    logic [W-1:0] prev_l = '0, prev_r = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (new_sample || frame_error) begin
                ev_t e;
                e.kind = (new_sample && frame_error) ? 3 : (new_sample ? 1 : 2);
                e.l = sample_l; e.r = sample_r; e.cyc = cyc; e.lk = locked;
                obs.push_back(e);
            end
            if (!new_sample && (sample_l !== prev_l || sample_r !== prev_r))
                bad_change = bad_change + 1;
        end
        prev_l = sample_l;
        prev_r = sample_r;
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic add_slot(input bit lr, input int len, input logic [W-1:0] word, input bit pad);
        slot_t s;
        s.lr = lr; s.len = len; s.word = word; s.pad = pad;
        slots.push_back(s);
    endtask

    task automatic send_bit(input bit lr, input bit d, output int rise);
        i2s_lrclk = lr;
        i2s_sdata = d;
        repeat (half) @(posedge clk);
        #2 i2s_bclk = 1'b1;
        rise = cyc;
        repeat (half) @(posedge clk);
        #2 i2s_bclk = 1'b0;
    endtask

    // Edge 0 is junk, edges 1..W carry the word MSB-first, the rest carry pad.
    task automatic play();
        int r;
        slot_rise.delete();
        foreach (slots[k]) begin
            for (int b = 0; b < slots[k].len; b++) begin
                bit d;
                if (b == 0) d = 1'($urandom);
                else if (b <= W) d = slots[k].word[W-b];
                else d = slots[k].pad;
                send_bit(slots[k].lr, d, r);
                if (b == 0) slot_rise.push_back(r);
            end
        end
    endtask

    function automatic logic [W-1:0] captured(input slot_t s);
        int nd = (s.len - 1 < W) ? s.len - 1 : W;
        logic [W-1:0] m = '1;
        m = m << (W - nd);
        return s.word & m;
    endfunction

    // Events happen when a slot closes, i.e. at the first bit of the next slot.
    task automatic build_expected();
        bit synced = 0;
        bit lok = 0;
        logic [W-1:0] lw = '0;
        expq.delete();
        for (int k = 1; k < slots.size(); k++) begin
            ev_t e;
            bit ok;
            if (slots[k].lr == slots[k-1].lr) continue;
            e.cyc = slot_rise[k] + 3; e.l = '0; e.r = '0; e.lk = 1'b1;
            ok = (slots[k-1].len - 1 >= W);
            if (!synced) begin
                if (slots[k].lr == 1'b0) synced = 1;
            end else if (slots[k-1].lr == 1'b0) begin
                lok = ok; lw = captured(slots[k-1]);
                if (!ok) begin e.kind = 2; expq.push_back(e); end
            end else begin
                if (!ok) begin e.kind = 2; expq.push_back(e); end
                else if (lok) begin
                    e.kind = 1; e.l = lw; e.r = captured(slots[k-1]);
                    expq.push_back(e);
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        int n;
        bit any_ns = 0;
        repeat (10) @(posedge clk);
        #1;
        build_expected();
        chk({tag, " event count"}, obs.size(), expq.size());
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s ev%0d kind", tag, i), obs[i].kind, expq[i].kind);
            chk($sformatf("%s ev%0d cycle", tag, i), obs[i].cyc, expq[i].cyc);
            if (expq[i].kind == 1) begin
                any_ns = 1;
                chk($sformatf("%s ev%0d sample_l", tag, i), obs[i].l, expq[i].l);
                chk($sformatf("%s ev%0d sample_r", tag, i), obs[i].r, expq[i].r);
                chk($sformatf("%s ev%0d locked", tag, i), obs[i].lk, 1'b1);
            end
        end
        chk({tag, " locked at end"}, locked, any_ns);
        chk({tag, " output changes without strobe"}, bad_change, 0);
    endtask

    task automatic start_scenario(input int hp);
        reset = 1'b1;
        i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        half = hp;
        obs.delete();
        slots.delete();
    endtask

    task automatic add_frames(input int n, input logic [W-1:0] l, input logic [W-1:0] r, input int len, input bit pad);
        for (int i = 0; i < n; i++) begin
            add_slot(1'b0, len, l, pad);
            add_slot(1'b1, len, r, pad);
        end
    endtask

    initial begin
        // Reset held while inputs toggle, then release with lrclk static.
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2 i2s_bclk = 1'($urandom); i2s_lrclk = 1'($urandom); i2s_sdata = 1'($urandom);
        end
        chk("reset sample_l", sample_l, 0);
        chk("reset sample_r", sample_r, 0);
        chk("reset new_sample", new_sample, 0);
        chk("reset frame_error", frame_error, 0);
        chk("reset locked", locked, 0);
        i2s_bclk = 1'b0; i2s_lrclk = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        half = 6;
        obs.delete(); slots.delete();
        add_slot(1'b1, 40, W'($urandom), 1'b1);
        play();
        compare("idle");

        // Nominal: bclk = clk/32, 32-bit slots, three frames.
        start_scenario(16);
        add_slot(1'b1, 32, 24'h000000, 1'b0);
        add_frames(3, 24'h123456, 24'hFEDCBA, 32, 1'b0);
        add_slot(1'b0, 32, 24'h123456, 1'b0);
        play();
        compare("nominal");

        // Trailing bits beyond the word are all ones and must be ignored.
        start_scenario(6);
        add_slot(1'b1, 32, 24'h000000, 1'b1);
        add_frames(2, 24'h800001, 24'h7FFFFF, 32, 1'b1);
        add_slot(1'b0, 32, 24'h800001, 1'b1);
        play();
        compare("trailing");

        // Short left slot with 16 data edges between two good frames.
        start_scenario(6);
        add_slot(1'b1, 32, 24'h000000, 1'b0);
        add_frames(1, 24'h111111, 24'h222222, 32, 1'b0);
        add_slot(1'b0, 17, 24'hABCD00, 1'b0);
        add_slot(1'b1, 32, 24'h333333, 1'b0);
        add_frames(1, 24'h444444, 24'h555555, 32, 1'b0);
        add_slot(1'b0, 32, 24'h666666, 1'b0);
        play();
        compare("short slot");

        // Release during a right slot.
        start_scenario(6);
        add_slot(1'b1, 14, 24'h0F0F0F, 1'b0);
        add_frames(2, 24'hA5A5A5, 24'h5A5A5A, 30, 1'b0);
        add_slot(1'b0, 30, 24'h000001, 1'b0);
        play();
        compare("mid-frame start");

        // Reset asserted 10 bits into a left slot.
        start_scenario(6);
        add_slot(1'b1, 32, 24'h000000, 1'b0);
        add_frames(2, 24'hC0FFEE, 24'hBEEF01, 32, 1'b0);
        add_slot(1'b0, 11, 24'h123123, 1'b0);
        play();
        compare("pre reset mid-word");
        reset = 1'b1;
        #1;
        chk("mid-word reset sample_l", sample_l, 0);
        chk("mid-word reset sample_r", sample_r, 0);
        chk("mid-word reset locked", locked, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        obs.delete(); slots.delete();
        add_slot(1'b0, 21, 24'h777777, 1'b0);
        add_slot(1'b1, 32, 24'h888888, 1'b0);
        add_frames(2, 24'h0ABCDE, 24'hF01234, 32, 1'b0);
        add_slot(1'b0, 32, 24'h999999, 1'b0);
        play();
        compare("post reset mid-word");

        // Randomized streams with random slot lengths, words and short slots.
        for (int it = 0; it < 3; it++) begin
            bit lr;
            start_scenario(4 + int'($urandom_range(0, 2)));
            lr = 1'($urandom);
            add_slot(lr, 1 + int'($urandom_range(0, 39)), W'($urandom), 1'($urandom));
            for (int s = 0; s < 11; s++) begin
                int len;
                lr = ~lr;
                if ($urandom_range(0, 5) == 0) len = 1 + int'($urandom_range(0, W - 1));
                else len = W + 1 + int'($urandom_range(0, 7));
                add_slot(lr, len, W'($urandom), 1'($urandom));
            end
            play();
            compare($sformatf("random%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_rx_deserializer.md
# i2s_rx_deserializer

Receive-direction I2S deserializer for the ADAU1761 capture path: it samples the codec's serial ADC stream (bit clock, word clock, data) in the `clk_100` system domain. It reassembles left/right line-in words and presents each stereo pair as parallel samples with a one-cycle strobe. It pairs with the existing playback path, filling the `line_in_l`/`line_in_r` role for downstream capture, VU and wave-display logic.

## Interface
- `SAMPLE_WIDTH`, 24: captured bits per channel, MSB-first; legal range 1..32.
- `clk` input 1: system clock (`clk_100`); must be ≥ 4× `i2s_bclk` frequency.
- `reset` input 1: asynchronous, active-high; clears all state and outputs.
- `i2s_bclk` input 1: codec bit clock, asynchronous to `clk`.
- `i2s_lrclk` input 1: codec word clock, asynchronous; 0 = left slot, 1 = right slot.
- `i2s_sdata` input 1: codec serial ADC data, asynchronous.
- `sample_l` output SAMPLE_WIDTH: last complete left word, two's complement.
- `sample_r` output SAMPLE_WIDTH: last complete right word, two's complement.
- `new_sample` output 1: one-cycle strobe; `sample_l`/`sample_r` updated this cycle.
- `frame_error` output 1: one-cycle strobe; a slot ended with fewer than SAMPLE_WIDTH data bits.
- `locked` output 1: high once the first valid pair has been delivered.

## Operation
- Each of `i2s_bclk`, `i2s_lrclk`, `i2s_sdata` passes through a 2-flop synchronizer, plus one extra flop on bclk for edge detection. A bclk rising edge is `bclk_s2 & ~bclk_s3`. lrclk and sdata are taken from their s2 flops in the same cycle, so all three are aligned.
- All actions below occur only in cycles flagged as bclk rising edges. Other cycles hold state.
- Slot boundary: an edge where sampled lrclk differs from lrclk sampled at the previous rising edge. This is edge 0 of the new slot and carries no data; it is the previous word's trailing bit and is ignored.
- Data edges 1..SAMPLE_WIDTH of a slot shift sdata in MSB-first. Further edges in the slot are ignored.
- Slot bit counter is 6 bits and saturates at 63.
- A short slot (boundary reached with counter < SAMPLE_WIDTH) leaves the unfilled LSBs at 0 and marks the slot bad.
- States:
  - WAIT_SYNC (reset state): discard everything until a slot boundary with lrclk 1→0, then go to LEFT.
  - LEFT: capture into left shift register. At a 0→1 boundary, latch the left word into a holding register, record short/ok, and go to RIGHT.
  - RIGHT: capture into right shift register. At a 1→0 boundary:
    - Drive `sample_l` ← left holding and `sample_r` ← right word.
    - Pulse `new_sample` only if both slots are ok. Otherwise outputs are not updated and no strobe is given.
    - Go to LEFT.
- `frame_error` pulses at the boundary edge that ends any short slot in LEFT or RIGHT. It never pulses in WAIT_SYNC.
- No resync after errors; the alternation of lrclk keeps the alignment.
- `locked` sets on the first `new_sample` and clears only on reset.
- Reset mid-word: all registers clear at once. On release the block is in WAIT_SYNC, and the partial frame in flight is dropped.

## Timing
- Reset values: `sample_l` = 0, `sample_r` = 0, `new_sample` = 0, `frame_error` = 0, `locked` = 0, state = WAIT_SYNC, counters and shift registers = 0.
- Latency: let edge n be the first `clk` edge that samples `i2s_bclk` high. The outputs for that bclk edge are registered at `clk` edge n+2, so `new_sample`/`frame_error` are high for exactly the cycle following edge n+2.
- `sample_l`/`sample_r` change only in the same cycle that `new_sample` goes high, and hold until the next strobe.
- `new_sample` and `frame_error` are never both high: a pair closed by a short slot gives only `frame_error`.
- First `new_sample` comes at the second 1→0 lrclk boundary after sync, i.e. one full left+right frame after leaving WAIT_SYNC.

## Test plan
- Reset/idle: hold `reset`, toggle inputs → all outputs 0. Release with lrclk static → outputs stay 0, no strobes.
- Nominal stream: bclk = 100 MHz/32, 32-bit slots, left = 24'h123456, right = 24'hFEDCBA, 3 frames.
  - First strobe after the second 1→0 boundary: `sample_l` = 24'h123456, `sample_r` = 24'hFEDCBA.
  - Exactly one `new_sample` per frame, each 3 `clk` edges after the boundary bclk rise; `locked` = 1 after the first strobe.
- Trailing bits ignored: 32-bit slots whose bits 25..32 are all 1, data words 24'h800001 / 24'h7FFFFF → outputs exactly 24'h800001 / 24'h7FFFFF.
- Short slot: one left slot with 16 data edges carrying 16'hABCD, then normal frames → one `frame_error` pulse, no `new_sample` for that frame, previous outputs held; next frame updates normally.
- Start mid-frame: release reset during a right slot → no strobe until one full left+right frame has completed after the first 1→0 boundary.
- Reset mid-word: assert `reset` 10 bits into a left slot → outputs and `locked` clear immediately; after release the first strobe again needs one full frame after the next 1→0 boundary.
